alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that wraps one 1-bit ALU slice to perform a WIDTH-bit ALU operation over successive clock cycles. It accepts a full-width command, drives one bit position of the slice per cycle (LSB first), and feeds each slice carry back as the next cin. It collects result bits, runs a final compare pass for the set-less-than/compare operation, and returns a full-width result with flags. It sits directly upstream of the slice: every slice input comes from this block, and the slice's result/cout/set outputs return to it.

---
 rtl/alu_serial_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving an external 1-bit ALU slice, LSB first, with a final compare pass.
// Optional macro SLT_OVF_FIX_EN: compare "less" is corrected for subtraction overflow.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  input  logic [2:0]       cmpcontrol_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             done_o,
  output logic             slice_src1_o,
  output logic             slice_src2_o,
  output logic             slice_cin_o,
  output logic             slice_less_o,
  output logic             slice_equal_o,
  output logic             slice_A_invert_o,
  output logic             slice_B_invert_o,
  output logic [1:0]       slice_operation_o,
  output logic [2:0]       slice_cmpcontrol_o,
  input  logic             slice_result_i,
  input  logic             slice_cout_i,
  input  logic             slice_set_i
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_CMP   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [2:0]       cmp_q, cmp_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic             cout_msb_q, cout_msb_d;
  logic             set_msb_q, set_msb_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             less_s;

`ifdef SLT_OVF_FIX_EN
  assign less_s = set_msb_q ^ ovf_q;
`else
  assign less_s = set_msb_q;
`endif

  // Next-state and datapath update for the serial sequencer.
  always_comb begin
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    ctrl_d     = ctrl_q;
    cmp_d      = cmp_q;
    k_d        = k_q;
    res_d      = res_q;
    carry_d    = carry_q;
    eq_d       = eq_q;
    cout_msb_d = cout_msb_q;
    set_msb_d  = set_msb_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src1_d  = src1_i;
          src2_d  = src2_i;
          ctrl_d  = ALU_control_i;
          cmp_d   = cmpcontrol_i;
          k_d     = '0;
          res_d   = '0;
          eq_d    = 1'b1;
          carry_d = ALU_control_i[2];
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Operands rotate so bit 0 is back in place for the compare pass.
        src1_d  = {src1_q[0], src1_q[WIDTH-1:1]};
        src2_d  = {src2_q[0], src2_q[WIDTH-1:1]};
        res_d   = {slice_result_i, res_q[WIDTH-1:1]};
        carry_d = slice_cout_i;
        eq_d    = eq_q & ~slice_set_i;
        if (k_q == K_LAST) begin
          cout_msb_d = slice_cout_i;
          set_msb_d  = slice_set_i;
          ovf_d      = carry_q ^ slice_cout_i;
          state_d    = (ctrl_q[1:0] == 2'b11) ? S_CMP : S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_CMP: begin
        res_d   = {{(WIDTH-1){1'b0}}, slice_result_i};
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered user-facing outputs, refreshed only on entry to DONE.
  always_comb begin
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    done_d     = (state_d == S_DONE);
    ready_d    = (state_d == S_IDLE);
    if (state_d == S_DONE) begin
      result_d   = res_d;
      zero_d     = (res_d == '0);
      cout_d     = ctrl_q[1] & cout_msb_d;
      overflow_d = ctrl_q[1] & ovf_d;
    end else begin
      done_d = 1'b0;
    end
  end

  // Slice drive decoded from the current state.
  always_comb begin
    slice_src1_o       = 1'b0;
    slice_src2_o       = 1'b0;
    slice_cin_o        = 1'b0;
    slice_less_o       = 1'b0;
    slice_equal_o      = 1'b0;
    slice_A_invert_o   = 1'b0;
    slice_B_invert_o   = 1'b0;
    slice_operation_o  = 2'b00;
    slice_cmpcontrol_o = 3'b000;
    case (state_q)
      S_SHIFT: begin
        slice_src1_o       = src1_q[0];
        slice_src2_o       = src2_q[0];
        slice_cin_o        = carry_q;
        slice_A_invert_o   = ctrl_q[3];
        slice_B_invert_o   = ctrl_q[2];
        slice_operation_o  = (ctrl_q[1:0] == 2'b11) ? 2'b10 : ctrl_q[1:0];
        slice_cmpcontrol_o = cmp_q;
      end
      S_CMP: begin
        slice_src1_o       = src1_q[0];
        slice_src2_o       = src2_q[0];
        slice_A_invert_o   = ctrl_q[3];
        slice_B_invert_o   = ctrl_q[2];
        slice_operation_o  = 2'b11;
        slice_less_o       = less_s;
        slice_equal_o      = eq_q;
        slice_cmpcontrol_o = cmp_q;
      end
      default: begin
        slice_operation_o = 2'b00;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      ctrl_q     <= 4'b0000;
      cmp_q      <= 3'b000;
      k_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      eq_q       <= 1'b1;
      cout_msb_q <= 1'b0;
      set_msb_q  <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      ctrl_q     <= ctrl_d;
      cmp_q      <= cmp_d;
      k_q        <= k_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      eq_q       <= eq_d;
      cout_msb_q <= cout_msb_d;
      set_msb_q  <= set_msb_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = overflow_q;
  assign done_o     = done_q;
  assign ready_o    = ready_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: behavioural 1-bit slice plus full-width reference model.
module tb_alu_serial_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        ready_o;
  logic [31:0] src1_i, src2_i;
  logic [3:0]  ALU_control_i;
  logic [2:0]  cmpcontrol_i;
  logic [31:0] result_o;
  logic        zero_o, cout_o, overflow_o, done_o;
  logic        slice_src1_o, slice_src2_o, slice_cin_o, slice_less_o, slice_equal_o;
  logic        slice_A_invert_o, slice_B_invert_o;
  logic [1:0]  slice_operation_o;
  logic [2:0]  slice_cmpcontrol_o;
  logic        slice_result_i, slice_cout_i, slice_set_i;

  int n_checks = 0;
  int n_errors = 0;

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
    .src1_i(src1_i), .src2_i(src2_i), .ALU_control_i(ALU_control_i),
    .cmpcontrol_i(cmpcontrol_i), .result_o(result_o), .zero_o(zero_o),
    .cout_o(cout_o), .overflow_o(overflow_o), .done_o(done_o),
    .slice_src1_o(slice_src1_o), .slice_src2_o(slice_src2_o),
    .slice_cin_o(slice_cin_o), .slice_less_o(slice_less_o),
    .slice_equal_o(slice_equal_o), .slice_A_invert_o(slice_A_invert_o),
    .slice_B_invert_o(slice_B_invert_o), .slice_operation_o(slice_operation_o),
    .slice_cmpcontrol_o(slice_cmpcontrol_o), .slice_result_i(slice_result_i),
    .slice_cout_i(slice_cout_i), .slice_set_i(slice_set_i)
  );

  always #5 clk_i = ~clk_i;

  // Compare selector semantics of the slice attached in this bench.
  function automatic logic cmp_fn(input logic [2:0] sel, input logic less, input logic eq);
    case (sel)
      3'd0:    return less;
      3'd1:    return ~less & ~eq;
      3'd2:    return less | eq;
      3'd3:    return ~less;
      3'd4:    return eq;
      3'd5:    return ~eq;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural 1-bit ALU slice.
  logic sa, sb;
  always_comb begin
    sa = slice_src1_o ^ slice_A_invert_o;
    sb = slice_src2_o ^ slice_B_invert_o;
    slice_set_i  = sa ^ sb ^ slice_cin_o;
    slice_cout_i = (sa & sb) | (sa & slice_cin_o) | (sb & slice_cin_o);
    case (slice_operation_o)
      2'b00:   slice_result_i = sa & sb;
      2'b01:   slice_result_i = sa | sb;
      2'b10:   slice_result_i = slice_set_i;
      default: slice_result_i = cmp_fn(slice_cmpcontrol_o, slice_less_o, slice_equal_o);
    endcase
  end

  // Full-width reference; compare is modelled for control 4'b0111 (a - b).
  function automatic void ref_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] sel, output logic [31:0] r,
                                 output logic c, output logic v);
    logic [31:0] a2, b2;
    logic [32:0] s;
    logic        less;
    a2 = ctrl[3] ? ~a : a;
    b2 = ctrl[2] ? ~b : b;
    s  = {1'b0, a2} + {1'b0, b2} + {32'd0, ctrl[2]};
    v  = (a2[31] == b2[31]) && (s[31] != a2[31]);
    c  = s[32];
`ifdef SLT_OVF_FIX_EN
    less = ($signed(a) < $signed(b));
`else
    less = s[31];
`endif
    case (ctrl[1:0])
      2'b00:   begin r = a2 & b2; c = 1'b0; v = 1'b0; end
      2'b01:   begin r = a2 | b2; c = 1'b0; v = 1'b0; end
      2'b10:   r = s[31:0];
      default: r = {31'd0, cmp_fn(sel, less, a == b)};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, ready_o, 32'd1);
    check_eq({tag, "_result"}, result_o, 32'd0);
    check_eq({tag, "_flags"}, {zero_o, cout_o, overflow_o, done_o}, 32'b1000);
    check_eq({tag, "_slice"}, {slice_src1_o, slice_src2_o, slice_cin_o, slice_less_o,
             slice_equal_o, slice_A_invert_o, slice_B_invert_o, slice_operation_o,
             slice_cmpcontrol_o}, 32'd0);
  endtask

  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] sel, input bit hold, input string tag,
                        output logic [31:0] got);
    logic [31:0] er;
    logic        ec, ev;
    int          cyc, lat;
    ref_op(ctrl, a, b, sel, er, ec, ev);
    lat = (ctrl[1:0] == 2'b11) ? 34 : 33;
    src1_i = a; src2_i = b; ALU_control_i = ctrl; cmpcontrol_i = sel;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    cyc = 1;
    if (!hold) start_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom;
    ALU_control_i = 4'($urandom); cmpcontrol_i = 3'($urandom);
    check_eq({tag, "_busy"}, ready_o, 32'd0);
    while (!done_o && cyc < 80) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    check_eq({tag, "_latency"}, cyc, lat);
    check_eq({tag, "_result"}, result_o, er);
    check_eq({tag, "_flags"}, {zero_o, cout_o, overflow_o}, {29'd0, er == 32'd0, ec, ev});
    got = result_o;
    @(posedge clk_i); #1;
    check_eq({tag, "_after"}, {done_o, ready_o}, 32'b01);
  endtask

  logic [31:0] got;
  logic [3:0]  ctrl_tab [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  logic [31:0] exp_ovf_cmp;

  initial begin
    rst_i = 1'b0; start_i = 1'b0;
    src1_i = '0; src2_i = '0; ALU_control_i = '0; cmpcontrol_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("rst_init");
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("idle_init");

    run_op(4'b0010, 32'd5, 32'd7, 3'd0, 1'b0, "add_5_7", got);
    check_eq("add_5_7_val", got, 32'd12);
    run_op(4'b0110, 32'h8000_0000, 32'd1, 3'd0, 1'b0, "sub_ovf", got);
    check_eq("sub_ovf_val", got, 32'h7FFF_FFFF);
    run_op(4'b0110, 32'd9, 32'd9, 3'd0, 1'b0, "sub_zero", got);
    check_eq("sub_zero_val", got, 32'd0);
    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 1'b0, "and", got);
    check_eq("and_val", got, 32'hF000_F000);
    run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 1'b0, "or", got);
    check_eq("or_val", got, 32'hFFF0_FFF0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, "slt_neg", got);
    check_eq("slt_neg_val", got, 32'd1);
`ifdef SLT_OVF_FIX_EN
    exp_ovf_cmp = 32'd0;
`else
    exp_ovf_cmp = 32'd1;
`endif
    run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 3'd0, 1'b0, "slt_ovf", got);
    check_eq("slt_ovf_val", got, exp_ovf_cmp);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd3, 3'd0, 1'b1, "add_hold", got);
    check_eq("add_hold_val", got, 32'd2);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 5 == 0) ? a : 32'($urandom);
      if (i % 7 == 3) a = 32'h8000_0000;
      run_op(ctrl_tab[$urandom_range(0, 5)], a, b, 3'($urandom_range(0, 5)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), got);
    end

    // Abandon an operation mid-flight with an asynchronous reset.
    src1_i = 32'd3; src2_i = 32'd4; ALU_control_i = 4'b0010; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check_eq("rst_hold_done", done_o, 32'd0);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("rst_release");
    run_op(4'b0010, 32'd100, 32'd23, 3'd0, 1'b0, "add_post_rst", got);
    check_eq("add_post_rst_val", got, 32'd123);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
